ebu75_checker: RTL and testbench
================================

Name: ebu75_checker

Overview:
- Receive-side monitor for the EBU 75% colour-bar pixel stream.
- Sits on the same luma/yuv_u/yuv_v bus that feeds the composite encoder, and on the same newline/newpixel/visible_window timing.
- Tracks the horizontal bar position itself and compares every qualified sample against the expected bar value, within a tolerance.
- Reports a per-frame pass/fail verdict, an error count and the first error location, and asserts lock after N consecutive clean frames.

Parameters:
- TOL, 2: max absolute deviation allowed per component (luma, U, V).
- LOCK_FRAMES, 4: consecutive passing frames required to assert locked.
- ERR_W, 16: width of the error counter.
- CHECK_BLANK, 1: when 1, samples outside visible_window must be exactly 0/0/0.

Ports:
- clk  in  1  pixel-domain clock
- rst_n  in  1  synchronous active-low reset
- newframe  in  1  one-cycle pulse at frame start
- newline  in  1  one-cycle pulse at line start
- newpixel  in  1  pixel strobe
- visible_window  in  1  active picture region
- video_y  in  9  current line number
- luma  in  8  unsigned luma sample
- yuv_u  in  8  signed U sample
- yuv_v  in  8  signed V sample
- frame_done  out  1  one-cycle pulse when a frame verdict is published
- frame_pass  out  1  verdict of the last completed frame
- err_count  out  ERR_W  mismatching samples in the last completed frame (saturating)
- first_err_x  out  8  pixel index of the first mismatch in the last frame
- first_err_y  out  9  line of the first mismatch in the last frame
- bars_seen  out  8  one bit per bar index observed in the last frame
- locked  out  1  LOCK_FRAMES consecutive passing frames

Behaviour:
- Reset (rst_n=0 at a clk edge): all outputs 0, all accumulators 0, pixel counter 0, state IDLE. A reset mid-frame discards the partial frame and produces no frame_done.
- Pixel counter px (8 bit):
  - newline clears px to 0.
  - A qualified pixel (visible_window && newpixel) increments px. If both occur in the same cycle, the increment wins: px <= px+1. This mirrors the bar source exactly.
  - px wraps 255 -> 0.
- Expected value: bar = px[7:5], looked up in the shared table, using px before the increment on that cycle.
- Compare: diff = input - expected, evaluated at 10-bit signed width (luma zero-extended, U/V sign-extended). A mismatch is |diff| > TOL on any component.
- Blank check: if CHECK_BLANK, newpixel && !visible_window is a mismatch unless luma, U and V are all exactly 0.
- States:
  - IDLE: ignore samples; newframe -> CHECK with accumulators cleared, no report.
  - CHECK: on every qualified sample, set bars_seen_acc[bar]. On a mismatch, err_acc saturating-increments; on the first mismatch, latch px and video_y. On newframe, publish and stay in CHECK.
- Publish, one cycle after newframe (registered):
  - frame_done=1 for exactly one cycle.
  - frame_pass = (err_acc==0) && (bars_seen_acc==8'hFF).
  - err_count, first_err_x/y and bars_seen are loaded from the accumulators.
  - first_err_x/y = 0 when there are no errors.
- Simultaneous newframe and qualified pixel: publish uses accumulators excluding that sample. The sample is checked and counted into the freshly cleared accumulators of the new frame.
- Lock counter: saturating at LOCK_FRAMES; +1 on a passing publish, cleared to 0 on a failing publish. locked = (count==LOCK_FRAMES), updated together with frame_done.
- err_count saturates at 2^ERR_W-1 and never wraps.
- Outputs hold between publishes.

Decomposition:
- Package ebu75_pkg, shared with the bar generator:
  - typedef ycc_t {luma 8 bit unsigned, u/v 8 bit signed}
  - constant array EBU75_BARS[8] of ycc_t:
    - bar 0: 255/0/0
    - bar 1: 168/-41/9
    - bar 2: 133/14/-58
    - bar 3: 112/-27/-49
    - bar 4: 76/27/49
    - bar 5: 56/-14/58
    - bar 6: 20/41/-9
    - bar 7: 0/0/0
  - enum chk_state_t {IDLE, CHECK}
- Sub-module ycc_tol_compare: combinational, takes sample, expected and TOL, outputs mismatch.
- Counters, state machine and publish logic stay in the top module.

Test Plan:
- Ideal frames: drive the bar generator for 3 frames with 256 visible pixels/line and 4 lines. Required per publish: frame_pass=1, err_count=0, bars_seen=8'hFF. locked must stay 0 through the 3rd publish. A 4th clean frame must set locked=1.
- Tolerance edge: offset luma +2 on all samples -> pass. Offset +3 -> fail, err_count=1024, first_err_x=0, first_err_y=0. U of bar 2 at 12 passes; U of bar 2 at 11 fails.
- Single error: corrupt V at px=100 on line 7 -> err_count=1, first_err_x=100, first_err_y=7, frame_pass=0. locked must drop to 0 and lock counter restart.
- Missing bars: visible width of 128 pixels -> bars_seen=8'h0F, frame_pass=0 despite err_count=0.
- Collisions:
  - newline coincident with a qualified pixel -> that sample is checked against the current px, and px = old+1 afterwards.
  - newframe coincident with a pixel -> the sample counts only in the next frame's totals.
- Reset mid-frame, then resume: frame_done must not pulse until the second newframe after reset. Also drive 70000 corrupt samples -> err_count=65535, no wrap.

Source files
------------

// File: rtl/ebu75_pkg.sv
// Shared definitions for the EBU 75% colour-bar generator and checker.
// Holds the YCbCr sample type, the bar value table and the checker states.
package ebu75_pkg;

    typedef struct packed {
        logic [7:0]        luma;
        logic signed [7:0] u;
        logic signed [7:0] v;
    } ycc_t;

    // Packed with bar 7 in the MSBs so EBU75_BARS[i] returns bar i.
    // Fields per entry: luma / U / V, U and V in two's complement.
    localparam ycc_t [7:0] EBU75_BARS = {
        24'h00_00_00,  // bar 7:   0/  0/  0
        24'h14_29_F7,  // bar 6:  20/ 41/ -9
        24'h38_F2_3A,  // bar 5:  56/-14/ 58
        24'h4C_1B_31,  // bar 4:  76/ 27/ 49
        24'h70_E5_CF,  // bar 3: 112/-27/-49
        24'h85_0E_C6,  // bar 2: 133/ 14/-58
        24'hA8_D7_09,  // bar 1: 168/-41/  9
        24'hFF_00_00   // bar 0: 255/  0/  0
    };

    typedef enum logic {
        IDLE  = 1'b0,
        CHECK = 1'b1
    } chk_state_t;

endpackage

// File: rtl/ycc_tol_compare.sv
// Per-component tolerance compare of a received YCbCr sample.
// Ports: sample_i, expect_i (ycc_t); mismatch_o high if any |diff| > TOL.
module ycc_tol_compare
    import ebu75_pkg::*;
#(
    parameter int TOL = 2
) (
    input  ycc_t sample_i,
    input  ycc_t expect_i,
    output logic mismatch_o
);

    localparam logic signed [9:0] TOL_V = 10'(TOL);

    logic signed [9:0] dy;
    logic signed [9:0] du;
    logic signed [9:0] dv;

    // 10 bits hold any 8-bit difference without overflow.
    assign dy = $signed({2'b00, sample_i.luma})
              - $signed({2'b00, expect_i.luma});
    assign du = $signed({{2{sample_i.u[7]}}, sample_i.u})
              - $signed({{2{expect_i.u[7]}}, expect_i.u});
    assign dv = $signed({{2{sample_i.v[7]}}, sample_i.v})
              - $signed({{2{expect_i.v[7]}}, expect_i.v});

    function automatic logic over_tol(input logic signed [9:0] d);
        logic signed [9:0] a;
        a = (d < 0) ? -d : d;
        return a > TOL_V;
    endfunction

    assign mismatch_o = over_tol(dy) | over_tol(du) | over_tol(dv);

endmodule

// File: rtl/ebu75_checker.sv
// Receive-side monitor for the EBU 75% bar stream: tracks bar position,
// checks each sample within tolerance and publishes a verdict per frame.
// Inputs: clk, rst_n (sync, active low), newframe, newline, newpixel,
//   visible_window, video_y[8:0], luma[7:0], yuv_u[7:0], yuv_v[7:0].
// Outputs: frame_done, frame_pass, err_count, first_err_x/y, bars_seen,
//   locked.
module ebu75_checker
    import ebu75_pkg::*;
#(
    parameter int TOL         = 2,
    parameter int LOCK_FRAMES = 4,
    parameter int ERR_W       = 16,
    parameter int CHECK_BLANK = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             newframe,
    input  logic             newline,
    input  logic             newpixel,
    input  logic             visible_window,
    input  logic [8:0]       video_y,
    input  logic [7:0]       luma,
    input  logic [7:0]       yuv_u,
    input  logic [7:0]       yuv_v,
    output logic             frame_done,
    output logic             frame_pass,
    output logic [ERR_W-1:0] err_count,
    output logic [7:0]       first_err_x,
    output logic [8:0]       first_err_y,
    output logic [7:0]       bars_seen,
    output logic             locked
);

    localparam int LW = $clog2(LOCK_FRAMES + 1);
    localparam logic [LW-1:0]    LOCK_MAX = LW'(LOCK_FRAMES);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    chk_state_t       state_q, state_d;
    logic [7:0]       px_q, px_d;
    logic [ERR_W-1:0] err_acc_q, err_acc_d;
    logic [7:0]       fx_acc_q, fx_acc_d;
    logic [8:0]       fy_acc_q, fy_acc_d;
    logic [7:0]       bars_acc_q, bars_acc_d;

    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [7:0]       fx_q, fx_d;
    logic [8:0]       fy_q, fy_d;
    logic [7:0]       bars_q, bars_d;
    logic [LW-1:0]    lock_cnt_q, lock_cnt_d;
    logic             locked_q, locked_d;

    logic       qual;
    logic [2:0] bar;
    ycc_t       smp;
    ycc_t       exp_s;
    logic       cmp_mis;
    logic       blank_err;
    logic       sample_err;
    logic       publish;
    logic       take;
    logic       frame_ok;

    assign qual  = visible_window & newpixel;
    assign bar   = px_q[7:5];
    assign smp   = {luma, yuv_u, yuv_v};
    assign exp_s = EBU75_BARS[bar];

    ycc_tol_compare #(
        .TOL (TOL)
    ) u_cmp (
        .sample_i   (smp),
        .expect_i   (exp_s),
        .mismatch_o (cmp_mis)
    );

    assign blank_err = (CHECK_BLANK != 0) && newpixel && !visible_window
                    && ((luma | yuv_u | yuv_v) != 8'd0);
    assign sample_err = (qual && cmp_mis) || blank_err;

    // Increment beats newline, matching how the bar source counts.
    always_comb begin
        px_d = px_q;
        if (qual) begin
            px_d = px_q + 8'd1;
        end else if (newline) begin
            px_d = 8'd0;
        end
    end

    // A newframe sample belongs to the new frame, so it is folded into
    // the cleared accumulators while the old ones are published.
    assign publish  = (state_q == CHECK) && newframe;
    assign take     = (state_q == CHECK) || newframe;
    assign frame_ok = (err_acc_q == '0) && (bars_acc_q == 8'hFF);

    always_comb begin
        state_d    = state_q;
        err_acc_d  = err_acc_q;
        fx_acc_d   = fx_acc_q;
        fy_acc_d   = fy_acc_q;
        bars_acc_d = bars_acc_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        err_cnt_d  = err_cnt_q;
        fx_d       = fx_q;
        fy_d       = fy_q;
        bars_d     = bars_q;
        lock_cnt_d = lock_cnt_q;
        locked_d   = locked_q;

        case (state_q)
            IDLE:    if (newframe) state_d = CHECK;
            CHECK:   state_d = CHECK;
            default: state_d = IDLE;
        endcase

        if (newframe) begin
            err_acc_d  = '0;
            fx_acc_d   = 8'd0;
            fy_acc_d   = 9'd0;
            bars_acc_d = 8'd0;
        end

        if (publish) begin
            done_d    = 1'b1;
            pass_d    = frame_ok;
            err_cnt_d = err_acc_q;
            bars_d    = bars_acc_q;
            fx_d      = (err_acc_q == '0) ? 8'd0 : fx_acc_q;
            fy_d      = (err_acc_q == '0) ? 9'd0 : fy_acc_q;
            if (!frame_ok) begin
                lock_cnt_d = '0;
            end else if (lock_cnt_q != LOCK_MAX) begin
                lock_cnt_d = lock_cnt_q + LW'(1);
            end
            locked_d = (lock_cnt_d == LOCK_MAX);
        end

        if (take) begin
            if (qual) begin
                bars_acc_d = bars_acc_d | (8'd1 << bar);
            end
            if (sample_err) begin
                if (err_acc_d == '0) begin
                    fx_acc_d = px_q;
                    fy_acc_d = video_y;
                end
                if (err_acc_d != ERR_MAX) begin
                    err_acc_d = err_acc_d + ERR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            px_q       <= 8'd0;
            err_acc_q  <= '0;
            fx_acc_q   <= 8'd0;
            fy_acc_q   <= 9'd0;
            bars_acc_q <= 8'd0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_cnt_q  <= '0;
            fx_q       <= 8'd0;
            fy_q       <= 9'd0;
            bars_q     <= 8'd0;
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            px_q       <= px_d;
            err_acc_q  <= err_acc_d;
            fx_acc_q   <= fx_acc_d;
            fy_acc_q   <= fy_acc_d;
            bars_acc_q <= bars_acc_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            err_cnt_q  <= err_cnt_d;
            fx_q       <= fx_d;
            fy_q       <= fy_d;
            bars_q     <= bars_d;
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= locked_d;
        end
    end

    assign frame_done  = done_q;
    assign frame_pass  = pass_q;
    assign err_count   = err_cnt_q;
    assign first_err_x = fx_q;
    assign first_err_y = fy_q;
    assign bars_seen   = bars_q;
    assign locked      = locked_q;

endmodule

// File: tb/tb_ebu75_checker.sv
// Directed testbench for ebu75_checker: drives a bar-generator model
// with controlled faults and checks each published frame verdict.
module tb_ebu75_checker;

    localparam int NO = 999;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        newframe;
    logic        newline;
    logic        newpixel;
    logic        visible_window;
    logic [8:0]  video_y;
    logic [7:0]  luma;
    logic [7:0]  yuv_u;
    logic [7:0]  yuv_v;
    logic        frame_done;
    logic        frame_pass;
    logic [15:0] err_count;
    logic [7:0]  first_err_x;
    logic [8:0]  first_err_y;
    logic [7:0]  bars_seen;
    logic        locked;

    int n_chk = 0;
    int n_err = 0;
    int lock_m = 0;

    int LY[8] = '{255, 168, 133, 112, 76, 56, 20, 0};
    int LU[8] = '{0, -41, 14, -27, 27, -14, 41, 0};
    int LV[8] = '{0, 9, -58, -49, 49, 58, -9, 0};

    always #5 clk = ~clk;

    ebu75_checker dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .newframe       (newframe),
        .newline        (newline),
        .newpixel       (newpixel),
        .visible_window (visible_window),
        .video_y        (video_y),
        .luma           (luma),
        .yuv_u          (yuv_u),
        .yuv_v          (yuv_v),
        .frame_done     (frame_done),
        .frame_pass     (frame_pass),
        .err_count      (err_count),
        .first_err_x    (first_err_x),
        .first_err_y    (first_err_y),
        .bars_seen      (bars_seen),
        .locked         (locked)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        newframe       = 1'b0;
        newline        = 1'b0;
        newpixel       = 1'b0;
        visible_window = 1'b0;
        luma           = 8'd0;
        yuv_u          = 8'd0;
        yuv_v          = 8'd0;
    endtask

    // Generator model. loff is a luma deviation magnitude, applied
    // downwards where upwards would leave the 8-bit range.
    task automatic set_pix(input int p, input int loff, input int u2,
                           input int vpx, input int vline, input int y);
        int b;
        int l;
        int u;
        int v;
        b = (p >> 5) & 7;
        l = LY[b];
        if (loff > 0) l = (l + loff > 255) ? l - loff : l + loff;
        u = LU[b];
        if (b == 2 && u2 != NO) u = u2;
        v = LV[b];
        if (p == vpx && y == vline) v = v + 5;
        newpixel       = 1'b1;
        visible_window = 1'b1;
        luma           = 8'(l);
        yuv_u          = 8'(u);
        yuv_v          = 8'(v);
    endtask

    task automatic body(input int nl, input int w, input int loff,
                        input int u2, input int vpx, input int vline);
        for (int y = 0; y < nl; y++) begin
            idle_in();
            newline = 1'b1;
            video_y = 9'(y);
            step();
            newline = 1'b0;
            for (int p = 0; p < w; p++) begin
                set_pix(p, loff, u2, vpx, vline, y);
                step();
            end
            idle_in();
            newpixel = 1'b1;
            step();
            step();
            newpixel = 1'b0;
            step();
        end
    endtask

    task automatic do_newframe();
        idle_in();
        newframe = 1'b1;
        step();
        newframe = 1'b0;
    endtask

    task automatic check_pub(input string tag, input int pass,
                             input int errs, input int x, input int y,
                             input int bars);
        if (pass != 0) lock_m = (lock_m < 4) ? lock_m + 1 : 4;
        else lock_m = 0;
        check({tag, ".done"}, frame_done, 1);
        check({tag, ".pass"}, frame_pass, pass);
        check({tag, ".errs"}, err_count, errs);
        check({tag, ".x"}, first_err_x, x);
        check({tag, ".y"}, first_err_y, y);
        check({tag, ".bars"}, bars_seen, bars);
        check({tag, ".locked"}, locked, (lock_m == 4) ? 1 : 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".done"}, frame_done, 0);
        check({tag, ".pass"}, frame_pass, 0);
        check({tag, ".errs"}, err_count, 0);
        check({tag, ".bars"}, bars_seen, 0);
        check({tag, ".locked"}, locked, 0);
    endtask

    initial begin
        idle_in();
        video_y = 9'd0;
        rst_n = 1'b0;
        step();
        step();
        check_zero("reset");
        check("reset.x", first_err_x, 0);
        check("reset.y", first_err_y, 0);
        rst_n = 1'b1;

        do_newframe();
        check("idle_nf.done", frame_done, 0);

        for (int f = 0; f < 4; f++) begin
            body(4, 256, 0, NO, -1, -1);
            do_newframe();
            check_pub($sformatf("ideal%0d", f), 1, 0, 0, 0, 8'hFF);
        end
        step();
        check("done_pulse", frame_done, 0);

        body(4, 256, 2, NO, -1, -1);
        do_newframe();
        check_pub("tol2", 1, 0, 0, 0, 8'hFF);

        body(8, 256, 0, NO, 100, 7);
        do_newframe();
        check_pub("single", 0, 1, 100, 7, 8'hFF);

        body(4, 256, 0, NO, -1, -1);
        do_newframe();
        check_pub("relock", 1, 0, 0, 0, 8'hFF);

        body(4, 256, 3, NO, -1, -1);
        do_newframe();
        check_pub("tol3", 0, 1024, 0, 0, 8'hFF);

        body(4, 256, 0, 12, -1, -1);
        do_newframe();
        check_pub("u12", 1, 0, 0, 0, 8'hFF);

        body(4, 256, 0, 11, -1, -1);
        do_newframe();
        check_pub("u11", 0, 128, 64, 0, 8'hFF);

        body(4, 128, 0, NO, -1, -1);
        do_newframe();
        check_pub("narrow", 0, 0, 0, 0, 8'h0F);

        // newline together with a pixel at px=40 (bar 1)
        idle_in();
        newline = 1'b1;
        video_y = 9'd0;
        step();
        newline = 1'b0;
        for (int p = 0; p < 40; p++) begin
            set_pix(p, 0, NO, -1, -1, 0);
            step();
        end
        set_pix(40, 0, NO, -1, -1, 1);
        newline = 1'b1;
        video_y = 9'd1;
        step();
        newline = 1'b0;
        for (int p = 41; p < 256; p++) begin
            set_pix(p, 0, NO, -1, -1, 1);
            step();
        end
        // newframe together with a bad pixel at px=0
        set_pix(0, 0, NO, -1, -1, 1);
        luma = 8'd0;
        newframe = 1'b1;
        step();
        idle_in();
        check_pub("col_nl", 1, 0, 0, 0, 8'hFF);

        body(1, 256, 0, NO, -1, -1);
        do_newframe();
        check_pub("col_nf", 0, 1, 0, 1, 8'hFF);

        // reset in the middle of a frame
        idle_in();
        newline = 1'b1;
        video_y = 9'd0;
        step();
        newline = 1'b0;
        for (int p = 0; p < 50; p++) begin
            set_pix(p, 3, NO, -1, -1, 0);
            step();
        end
        rst_n = 1'b0;
        step();
        step();
        check_zero("rst_mid");
        lock_m = 0;
        rst_n = 1'b1;
        for (int p = 50; p < 60; p++) begin
            set_pix(p, 3, NO, -1, -1, 0);
            step();
        end
        do_newframe();
        check("rst_nf1.done", frame_done, 0);
        body(4, 256, 0, NO, -1, -1);
        do_newframe();
        check_pub("rst_nf2", 1, 0, 0, 0, 8'hFF);

        // non-zero blanking samples, enough to saturate the counter
        idle_in();
        video_y = 9'd5;
        newpixel = 1'b1;
        luma = 8'd1;
        repeat (70000) step();
        do_newframe();
        check_pub("sat", 0, 65535, 0, 5, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
